// File: rtl/if_stage_pkg.sv
// Shared fetch-stage definitions: bus widths, stall encoding, icache geometry, FSM states.
package if_stage_pkg;

    localparam int STALL_W     = 6;
    localparam int INDEX_W     = 6;
    localparam int TAG_W       = 9;
    localparam int CACHE_DEPTH = 1 << INDEX_W;

    typedef logic [STALL_W-1:0] stall_bus_t;
    typedef logic [31:0]        inst_addr_t;
    typedef logic [31:0]        inst_t;
    typedef logic [INDEX_W-1:0] index_t;
    typedef logic [TAG_W-1:0]   tag_t;

    localparam logic  STOP      = 1'b1;
    localparam logic  NO_STOP   = 1'b0;
    localparam inst_t ZERO_WORD = 32'h0000_0000;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        DONE  = 2'd2
    } fetch_state_t;

    function automatic index_t pc_index(input inst_addr_t pc);
        return pc[7:2];
    endfunction

    function automatic tag_t pc_tag(input inst_addr_t pc);
        return pc[16:8];
    endfunction

endpackage

// File: rtl/if_stage_icache.sv
// 64-entry direct-mapped instruction cache: combinational lookup, synchronous fill,
// valid bits cleared asynchronously by reset.
module icache
    import if_stage_pkg::*;
(
    input  logic   clk,
    input  logic   rst,
    input  index_t rd_index,
    input  tag_t   rd_tag,
    output logic   hit,
    output inst_t  rd_data,
    input  logic   wr_en,
    input  index_t wr_index,
    input  tag_t   wr_tag,
    input  inst_t  wr_data
);

    logic [CACHE_DEPTH-1:0] valid;
    tag_t                   tag_mem  [CACHE_DEPTH];
    inst_t                  data_mem [CACHE_DEPTH];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid <= '0;
        end else if (wr_en) begin
            valid[wr_index] <= 1'b1;
        end
    end

    // NOTE: tag/data arrays carry no reset; the valid bits qualify every lookup,
    // so clearing the arrays would only prevent them mapping onto plain RAM.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            tag_mem[wr_index]  <= wr_tag;
            data_mem[wr_index] <= wr_data;
        end
    end

    assign hit     = valid[rd_index] && (tag_mem[rd_index] == rd_tag);
    assign rd_data = data_mem[rd_index];

endmodule

// File: rtl/if_stage.sv
// Instruction fetch stage: icache lookup with a byte-serial refill from mem_ctrl,
// branch redirect overriding any fetch in flight.
module if_stage
    import if_stage_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  stall_bus_t stall,
    input  logic       branch_flag_i,
    input  inst_addr_t branch_target_i,
    input  logic       mem_byte_valid_i,
    input  logic [7:0] mem_byte_i,
    output logic       mem_req_o,
    output inst_addr_t mem_addr_o,
    output logic       stallreq_o,
    output inst_addr_t if_pc,
    output inst_t      if_inst
);

    fetch_state_t state;
    inst_addr_t   pc;
    logic [1:0]   count;
    inst_t        word_buf;
    logic         cache_hit;
    inst_t        cache_data;
    logic         fill_en;
    logic         unused_stall;

    assign unused_stall = ^stall[STALL_W-1:1];

    // The last byte goes straight into the fill so the cache write lands on the same edge.
    assign fill_en = (state == FETCH) && mem_byte_valid_i && (count == 2'd3) && !branch_flag_i;

    icache u_icache (
        .clk      (clk),
        .rst      (rst),
        .rd_index (pc_index(pc)),
        .rd_tag   (pc_tag(pc)),
        .hit      (cache_hit),
        .rd_data  (cache_data),
        .wr_en    (fill_en),
        .wr_index (pc_index(pc)),
        .wr_tag   (pc_tag(pc)),
        .wr_data  ({mem_byte_i, word_buf[23:0]})
    );

    // NOTE: every output gets a default before the case so no path leaves it unassigned,
    // which would otherwise infer a latch.
    always_comb begin
        stallreq_o = 1'b1;
        if_inst    = ZERO_WORD;
        case (state)
            IDLE: begin
                if (cache_hit) begin
                    stallreq_o = 1'b0;
                    if_inst    = cache_data;
                end
            end
            DONE: begin
                stallreq_o = 1'b0;
                if_inst    = word_buf;
            end
            default: ;
        endcase
    end

    assign if_pc = pc;

    // NOTE: non-blocking assignments throughout so every register samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            pc         <= '0;
            count      <= '0;
            word_buf   <= ZERO_WORD;
            mem_req_o  <= 1'b0;
            mem_addr_o <= '0;
        end else if (branch_flag_i) begin
            state     <= IDLE;
            pc        <= branch_target_i & ~32'h3;
            count     <= '0;
            mem_req_o <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (cache_hit) begin
                        if (stall[0] == NO_STOP) pc <= pc + 32'd4;
                    end else begin
                        state      <= FETCH;
                        mem_req_o  <= 1'b1;
                        mem_addr_o <= pc;
                        count      <= '0;
                    end
                end
                FETCH: begin
                    if (mem_byte_valid_i) begin
                        word_buf[{count, 3'b000} +: 8] <= mem_byte_i;
                        count                          <= count + 2'd1;
                        if (count == 2'd3) begin
                            state     <= DONE;
                            mem_req_o <= 1'b0;
                        end
                    end
                end
                DONE: begin
                    if (stall[0] == NO_STOP) begin
                        state <= IDLE;
                        pc    <= pc + 32'd4;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
